// File: rtl/screen_projector.sv
// screen_projector
// Projects binary16 world positions onto integer screen coordinates, one
// channel per dimension, through a 4-stage valid/ready pipeline:
//   S1 binary16 -> signed Q16.16
//   S2 x Q8.8 scale, truncate toward zero to a 24-bit integer
//   S3 + offset
//   S4 clamp or wrap into OUT_WIDTH bits
// Optional feature macro: SCREEN_PROJECTOR_CLAMP_EN
//   defined   : clamp to [0, limit], clip[i] flags out-of-range sums
//   undefined : result wraps to OUT_WIDTH bits, clip is always 0
module screen_projector #(
    parameter int                        DIMS           = 2,
    parameter int                        OUT_WIDTH      = 12,
    parameter logic [DIMS*16-1:0]        DEFAULT_SCALE  = {16'h0B40, 16'h1400},
    parameter logic [DIMS*OUT_WIDTH-1:0] DEFAULT_OFFSET = {12'd90, 12'd160},
    parameter logic [DIMS*OUT_WIDTH-1:0] DEFAULT_LIMIT  = {12'd179, 12'd319}
) (
    input  logic                                       clk_in,
    input  logic                                       rst,
    input  logic [DIMS*16-1:0]                         f,
    input  logic                                       data_valid_in,
    output logic                                       ready_out,
    output logic [DIMS*OUT_WIDTH-1:0]                  result,
    output logic                                       data_valid_out,
    input  logic                                       ready_in,
    output logic [DIMS-1:0]                            clip,
    input  logic                                       cfg_we,
    input  logic [((DIMS > 1) ? $clog2(DIMS) : 1)-1:0] cfg_dim,
    input  logic [15:0]                                cfg_scale,
    input  logic [OUT_WIDTH-1:0]                       cfg_offset,
    input  logic [OUT_WIDTH-1:0]                       cfg_limit,
    output logic                                       busy
);

    // binary16 -> signed Q16.16. Subnormals flush to zero; exponents 30/31
    // (huge, Inf, NaN) saturate by sign; fraction bits below 2^-16 are dropped.
    function automatic logic signed [31:0] decode_half(input logic [15:0] h);
        logic [4:0]  e;
        logic [10:0] sig;
        logic [31:0] mag;
        e   = h[14:10];
        sig = {1'b1, h[9:0]};
        if (e == 5'd0)
            mag = 32'd0;
        else if (e >= 5'd30)
            mag = 32'h7FFF_FFFF;
        else if (e >= 5'd9)
            mag = {21'd0, sig} << (e - 5'd9);
        else
            mag = {21'd0, sig} >> (5'd9 - e);
        return h[15] ? -$signed(mag) : $signed(mag);
    endfunction

    // Q24.24 product -> 24-bit signed integer, rounding toward zero and
    // saturating symmetrically at +/-(2^23-1).
    function automatic logic signed [23:0] trunc_q24(input logic signed [47:0] p);
        logic [47:0] mag;
        logic [23:0] ip;
        mag = p[47] ? 48'(-p) : 48'(p);
        ip  = 24'(mag >> 24);
        if (ip > 24'h7F_FFFF)
            ip = 24'h7F_FFFF;
        return p[47] ? -$signed(ip) : $signed(ip);
    endfunction

    logic r_v1;
    logic r_v2;
    logic r_v3;
    logic r_v4;
    logic w_ce;
    logic w_accept;
    logic w_cfg_exec;

    // The whole pipeline moves only when the output slot is empty or drained.
    assign w_ce           = !r_v4 || ready_in;
    assign ready_out      = w_ce;
    assign w_accept       = data_valid_in && w_ce;
    assign busy           = r_v1 | r_v2 | r_v3 | r_v4;
    assign data_valid_out = r_v4;
    // Config may only change while nothing is in flight, so every sample
    // sees one consistent scale/offset/limit set from entry to exit.
    assign w_cfg_exec     = cfg_we && !busy && !w_accept;

    // Stage valid tags shift in lockstep on each pipeline advance.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_v4 <= 1'b0;
        end else if (w_ce) begin
            r_v1 <= data_valid_in;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_v4 <= r_v3;
        end
    end

    generate
        for (genvar gi = 0; gi < DIMS; gi++) begin : g_dim
            logic [15:0]            r_scale;
            logic [OUT_WIDTH-1:0]   r_offset;
            logic [OUT_WIDTH-1:0]   r_limit;
            logic signed [31:0]     r_s1_q;
            logic signed [23:0]     r_s2_i;
            logic signed [24:0]     r_s3_sum;
            logic [OUT_WIDTH-1:0]   r_res;
            logic                   r_clip;
            logic                   w_sel;
            logic signed [47:0]     w_prod;
            logic [OUT_WIDTH-1:0]   w_res;
            logic                   w_clip;

            // Out-of-range cfg_dim values never match any channel.
            assign w_sel  = w_cfg_exec && (32'(cfg_dim) == gi);
            // Scale is unsigned Q8.8, so it enters the signed multiply zero-extended.
            assign w_prod = $signed({{16{r_s1_q[31]}}, r_s1_q}) * $signed({32'd0, r_scale});

`ifdef SCREEN_PROJECTOR_CLAMP_EN
            // Clamp the offset sum into [0, limit] and flag any clamping.
            always_comb begin
                w_res  = r_s3_sum[OUT_WIDTH-1:0];
                w_clip = 1'b0;
                if (r_s3_sum[24]) begin
                    w_res  = '0;
                    w_clip = 1'b1;
                end else if (r_s3_sum > $signed({{(25-OUT_WIDTH){1'b0}}, r_limit})) begin
                    w_res  = r_limit;
                    w_clip = 1'b1;
                end
            end
`else
            // Plain modular wrap; limit and the sum's upper bits have no role here.
            logic w_unused_bits;
            assign w_res         = r_s3_sum[OUT_WIDTH-1:0];
            assign w_clip        = 1'b0;
            assign w_unused_bits = ^{r_limit, r_s3_sum[24:OUT_WIDTH]};
`endif

            // Per-channel configuration registers, written only while idle.
            always_ff @(posedge clk_in or posedge rst) begin
                if (rst) begin
                    r_scale  <= DEFAULT_SCALE[gi*16 +: 16];
                    r_offset <= DEFAULT_OFFSET[gi*OUT_WIDTH +: OUT_WIDTH];
                    r_limit  <= DEFAULT_LIMIT[gi*OUT_WIDTH +: OUT_WIDTH];
                end else if (w_sel) begin
                    r_scale  <= cfg_scale;
                    r_offset <= cfg_offset;
                    r_limit  <= cfg_limit;
                end
            end

            // Datapath stages; they load together with the valid tags and hold on stall.
            always_ff @(posedge clk_in or posedge rst) begin
                if (rst) begin
                    r_s1_q   <= '0;
                    r_s2_i   <= '0;
                    r_s3_sum <= '0;
                    r_res    <= '0;
                    r_clip   <= 1'b0;
                end else if (w_ce) begin
                    r_s1_q   <= decode_half(f[gi*16 +: 16]);
                    r_s2_i   <= trunc_q24(w_prod);
                    r_s3_sum <= $signed({r_s2_i[23], r_s2_i})
                              + $signed({{(25-OUT_WIDTH){1'b0}}, r_offset});
                    r_res    <= w_res;
                    r_clip   <= w_clip;
                end
            end

            assign result[gi*OUT_WIDTH +: OUT_WIDTH] = r_res;
            assign clip[gi]                          = r_clip;
        end
    endgenerate

endmodule

// File: tb/tb_screen_projector.sv
// Testbench for screen_projector: directed spec vectors followed by random
// traffic scored against an arithmetic reference model of the projection.
`timescale 1ns/1ps
module tb_screen_projector;
    localparam int DIMS = 2;
    localparam int OW   = 12;

    logic                 clk_in = 1'b0;
    logic                 rst;
    logic [DIMS*16-1:0]   f;
    logic                 data_valid_in;
    logic                 ready_out;
    logic [DIMS*OW-1:0]   result;
    logic                 data_valid_out;
    logic                 ready_in;
    logic [DIMS-1:0]      clip;
    logic                 cfg_we;
    logic [0:0]           cfg_dim;
    logic [15:0]          cfg_scale;
    logic [OW-1:0]        cfg_offset;
    logic [OW-1:0]        cfg_limit;
    logic                 busy;

    screen_projector dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .f              (f),
        .data_valid_in  (data_valid_in),
        .ready_out      (ready_out),
        .result         (result),
        .data_valid_out (data_valid_out),
        .ready_in       (ready_in),
        .clip           (clip),
        .cfg_we         (cfg_we),
        .cfg_dim        (cfg_dim),
        .cfg_scale      (cfg_scale),
        .cfg_offset     (cfg_offset),
        .cfg_limit      (cfg_limit),
        .busy           (busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [DIMS*OW-1:0] res;
        logic [DIMS-1:0]    clp;
        int                 acc;
        bit                 strict;
        bit                 seen;
    } exp_t;

    exp_t   q[$];
    int     n_assert = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     n_out    = 0;
    longint m_scale[DIMS];
    longint m_offset[DIMS];
    longint m_limit[DIMS];
    bit     dir_en     = 1'b0;
    logic [DIMS*OW-1:0] dir_res;
    logic [DIMS-1:0]    dir_clip;
    bit     strict_lat = 1'b1;
    bit     last_acc   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic model_defaults();
        m_scale[0]  = 'h1400;  m_scale[1]  = 'h0B40;
        m_offset[0] = 160;     m_offset[1] = 90;
        m_limit[0]  = 319;     m_limit[1]  = 179;
    endtask

    // Reference: real-valued decode, integer multiply, C-style division
    // (toward zero), then clamp or wrap.
    function automatic void model(input logic [DIMS*16-1:0] fin,
                                  output logic [DIMS*OW-1:0] r, output logic [DIMS-1:0] c);
        logic [15:0] h;
        int          e;
        longint      qv, iv, s;
        r = '0;
        c = '0;
        for (int d = 0; d < DIMS; d++) begin
            h = fin[d*16 +: 16];
            e = int'(h[14:10]);
            if (e == 0)
                qv = 0;
            else if (e >= 30)
                qv = 64'sd2147483647;
            else
                qv = longint'($floor(real'(1024 + int'(h[9:0])) * (2.0 ** (e - 9))));
            if (h[15])
                qv = -qv;
            iv = (qv * m_scale[d]) / 64'sd16777216;
            if (iv > 8388607)  iv = 8388607;
            if (iv < -8388607) iv = -8388607;
            s = iv + m_offset[d];
`ifdef SCREEN_PROJECTOR_CLAMP_EN
            if (s < 0) begin
                r[d*OW +: OW] = '0;
                c[d] = 1'b1;
            end else if (s > m_limit[d]) begin
                r[d*OW +: OW] = OW'(m_limit[d]);
                c[d] = 1'b1;
            end else begin
                r[d*OW +: OW] = OW'(s);
            end
`else
            r[d*OW +: OW] = OW'(s);
`endif
        end
    endfunction

    function automatic logic [15:0] rand_half();
        logic [4:0] e;
        case ($urandom_range(0, 9))
            0:       e = 5'd0;
            1:       e = 5'(30 + $urandom_range(0, 1));
            2:       e = 5'd29;
            default: e = 5'($urandom_range(1, 29));
        endcase
        return {1'($urandom_range(0, 1)), e, 10'($urandom)};
    endfunction

    // One clock: called just after a negedge with inputs already driven.
    task automatic cycle();
        logic [DIMS*OW-1:0] mr;
        logic [DIMS-1:0]    mc;
        bit                 busy_exp;
        bit                 acc;
        exp_t               hd;
        #1;
        cyc++;
        busy_exp = (q.size() != 0);
        chk("busy", busy, busy_exp);
        chk("ready_out", ready_out, !data_valid_out || ready_in);
        if (q.size() == 0) begin
            chk("idle_dvo", data_valid_out, 1'b0);
        end else if (data_valid_out) begin
            hd = q[0];
            if (!hd.seen) begin
                hd.seen = 1'b1;
                q[0] = hd;
                if (hd.strict) chk("latency", cyc - hd.acc, 4);
                else           chk("latency_min", (cyc - hd.acc) >= 4, 1'b1);
            end
            chk("result", result, hd.res);
            chk("clip", clip, hd.clp);
            if (ready_in) begin
                void'(q.pop_front());
                n_out++;
            end
        end else if (q[0].strict) begin
            chk("dvo_timing", data_valid_out, (cyc - q[0].acc) >= 4);
        end
        acc = data_valid_in && ready_out;
        if (cfg_we && !busy_exp && !acc) begin
            m_scale[cfg_dim]  = cfg_scale;
            m_offset[cfg_dim] = cfg_offset;
            m_limit[cfg_dim]  = cfg_limit;
        end
        if (acc) begin
            if (dir_en) begin
                mr = dir_res;
                mc = dir_clip;
            end else begin
                model(f, mr, mc);
            end
            q.push_back('{res: mr, clp: mc, acc: cyc, strict: strict_lat, seen: 1'b0});
        end
        last_acc = acc;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_dvo", data_valid_out, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_clip", clip, '0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        q.delete();
        model_defaults();
        #1;
        chk("ready_after_rst", ready_out, 1'b1);
    endtask

    task automatic send(input logic [DIMS*16-1:0] fv, input logic [DIMS*OW-1:0] er,
                        input logic [DIMS-1:0] ec);
        int guard;
        guard         = 0;
        f             = fv;
        data_valid_in = 1'b1;
        dir_en        = 1'b1;
        dir_res       = er;
        dir_clip      = ec;
        do begin
            cycle();
            guard++;
        end while (!last_acc && guard < 50);
        chk("send_accepted", last_acc, 1'b1);
        data_valid_in = 1'b0;
        dir_en        = 1'b0;
    endtask

    task automatic drain();
        int g;
        g             = 0;
        data_valid_in = 1'b0;
        ready_in      = 1'b1;
        cfg_we        = 1'b0;
        while (q.size() != 0 && g < 40) begin
            cycle();
            g++;
        end
        chk("drain_empty", q.size(), 0);
        cycle();
        cycle();
    endtask

    initial begin
        int k;
        int sent;
        int base;
        rst           = 1'b1;
        f             = '0;
        data_valid_in = 1'b0;
        ready_in      = 1'b1;
        cfg_we        = 1'b0;
        cfg_dim       = '0;
        cfg_scale     = '0;
        cfg_offset    = '0;
        cfg_limit     = '0;
        model_defaults();
        @(negedge clk_in);
        do_reset();

        // Defaults: y=0, x=4.0
        send(32'h0000_4400, {12'd90, 12'd240}, 2'b00);
        drain();
        // y=1.5, x=8.0: x lands one past the limit
`ifdef SCREEN_PROJECTOR_CLAMP_EN
        send(32'h3E00_4800, {12'd106, 12'd319}, 2'b01);
`else
        send(32'h3E00_4800, {12'd106, 12'd320}, 2'b00);
`endif
        drain();
        // y=-1.5, x=-8.0: truncation toward zero
        send(32'hBE00_C800, {12'd74, 12'd0}, 2'b00);
        drain();

        // Ten back-to-back samples, output stalled on cycles 5..8
        strict_lat    = 1'b0;
        base          = n_out;
        k             = 0;
        sent          = 0;
        f             = {rand_half(), rand_half()};
        data_valid_in = 1'b1;
        while (sent < 10 && k < 60) begin
            k++;
            ready_in = !(k >= 5 && k <= 8);
            cycle();
            if (last_acc) begin
                sent++;
                f = {rand_half(), rand_half()};
            end
        end
        drain();
        chk("ten_outputs", n_out - base, 10);
        strict_lat = 1'b1;

        // Config write while busy is dropped, then applied when idle
        cfg_dim    = 1'b0;
        cfg_scale  = 16'h0A00;
        cfg_offset = 12'd10;
        cfg_limit  = 12'd319;
        send(32'h0000_4000, {12'd90, 12'd200}, 2'b00);
        cfg_we = 1'b1;
        cycle();
        cfg_we = 1'b0;
        drain();
        send(32'h0000_4000, {12'd90, 12'd200}, 2'b00);
        drain();
        cfg_we = 1'b1;
        cycle();
        cfg_we = 1'b0;
        send(32'h0000_4000, {12'd90, 12'd30}, 2'b00);
        drain();

        // Random traffic, back-pressure and config attempts
        strict_lat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            f             = {rand_half(), rand_half()};
            data_valid_in = ($urandom_range(0, 3) != 0);
            ready_in      = ($urandom_range(0, 3) != 0);
            cfg_we        = ($urandom_range(0, 5) == 0);
            cfg_dim       = 1'($urandom_range(0, 1));
            cfg_scale     = 16'($urandom_range(0, 16'h3000));
            cfg_offset    = 12'($urandom);
            cfg_limit     = 12'($urandom);
            cycle();
        end
        drain();

        // Reset with three samples in flight; defaults must come back
        strict_lat = 1'b1;
        ready_in   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f             = {rand_half(), rand_half()};
            data_valid_in = 1'b1;
            cycle();
        end
        data_valid_in = 1'b0;
        do_reset();
        repeat (8) cycle();
        send(32'h0000_4400, {12'd90, 12'd240}, 2'b00);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
